alu_cmd_sequencer: RTL

Initiator-side front end for the team's combinational alu block. It accepts operation commands (opcode, operands, tag) on a valid/ready interface and drives registered operands and opcode into the alu. It samples the alu result and flags after a fixed wait, then returns them on a valid/ready response interface with backpressure. Sits between the decode/issue logic and the alu, so the alu only ever sees stable, registered inputs.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu opcodes, flag bit indices and sequencer state encoding
package alu_pkg;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_CMP  = 4'd10;
    localparam logic [3:0] OP_ROTL = 4'd11;
    localparam logic [3:0] OP_ROTR = 4'd12;
    localparam logic [3:0] OP_LAST = OP_ROTR;

    localparam int FLG_CARRY = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - registers alu commands, waits ALU_LAT cycles, returns result on a ready/valid response
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              sticky_ovf,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        rsp_tag_d   = rsp_tag_q;
        sticky_d    = sticky_q;
        op_count_d  = op_count_q;
        cmd_ready   = 1'b0;

        // A clear is applied first so a same-cycle ovf handshake below overrides it.
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_EXEC: begin
                if (wait_q == 4'd0) begin
                    rsp_y_d     = alu_y;
                    rsp_flags_d = {alu_ovf, alu_zero, alu_neg, alu_carry};
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                cmd_ready = rsp_ready;
                if (rsp_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    if (rsp_flags_q[FLG_OVF]) begin
                        sticky_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accepting in RESP overlaps the response handshake, so rsp_* may be reloaded here.
        if (cmd_valid && cmd_ready) begin
            rsp_tag_d = cmd_tag;
            if (cmd_op > OP_LAST) begin
                rsp_err_d   = 1'b1;
                rsp_y_d     = '0;
                rsp_flags_d = 4'd0;
                state_d     = ST_RESP;
            end else begin
                alu_a_d    = cmd_a;
                alu_b_d    = cmd_b;
                alu_ctrl_d = cmd_op;
                wait_d     = LAT_LOAD;
                state_d    = ST_EXEC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= 4'd0;
            rsp_y_q     <= '0;
            rsp_flags_q <= 4'd0;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= '0;
            sticky_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tag_q   <= rsp_tag_d;
            sticky_q    <= sticky_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_y       = rsp_y_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_tag     = rsp_tag_q;
    assign sticky_ovf  = sticky_q;
    assign op_count    = op_count_q;

endmodule
